// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM states, source select and round-robin pick.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } tx_state_e;

  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_DBG = 1'b1
  } src_e;

  localparam int unsigned ByteW = 8;

  // On a tie the source that did not win last time is served; a lone requester always wins.
  function automatic src_e rr_pick(logic cpu_pend, logic dbg_pend, src_e last);
    src_e pick;
    if (cpu_pend && dbg_pend) begin
      pick = (last == SRC_DBG) ? SRC_CPU : SRC_DBG;
    end else if (dbg_pend) begin
      pick = SRC_DBG;
    end else begin
      pick = SRC_CPU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read and registered full/empty/level.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LvlW = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LvlW-1:0]  level_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [LvlW-1:0]  level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push, do_pop;

  // Pointer/level next state; a push into a full FIFO is legal only alongside a pop.
  always_comb begin
    do_pop  = pop_i & ~empty_q;
    do_push = push_i & (~full_q | do_pop);
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (do_push) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
    full_d  = (level_d == LvlW'(Depth));
    empty_d = (level_d == '0);
  end

  // Control state register, synchronous active-high reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage array; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates CPU FIFO bytes and debug-monitor bytes onto a single UART transmit core.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned BUSY_TIMEOUT = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cpu_wr,
  input  logic [7:0]                  cpu_data,
  output logic                        cpu_full,
  output logic [$clog2(FIFO_DEPTH):0] cpu_level,
  input  logic                        dbg_req,
  input  logic [7:0]                  dbg_data,
  output logic                        dbg_ack,
  output logic [7:0]                  tx_data,
  output logic                        tx_en,
  input  logic                        tx_busy,
  input  logic                        err_clr,
  output logic                        overflow,
  output logic                        tx_timeout,
  output logic                        irq_empty
);

  localparam int unsigned CntW = $clog2(BUSY_TIMEOUT + 1);

  tx_state_e        state_q, state_d;
  src_e             last_q, last_d;
  src_e             grant;
  logic [ByteW-1:0] tx_data_q, tx_data_d;
  logic             dbg_ack_q, dbg_ack_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             overflow_q, overflow_d;
  logic             tx_timeout_q, tx_timeout_d;
  logic             timeout_set;
  logic             ovf_set;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ByteW-1:0] fifo_rdata;

  sync_fifo #(
    .Width (ByteW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (cpu_wr),
    .wdata_i (cpu_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (cpu_level)
  );

  // Transfer FSM: grant in IDLE, strobe in LAUNCH, then track the core's busy handshake.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    tx_data_d   = tx_data_q;
    dbg_ack_d   = 1'b0;
    cnt_d       = cnt_q;
    fifo_pop    = 1'b0;
    timeout_set = 1'b0;
    grant       = SRC_CPU;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty || dbg_req) begin
          grant   = rr_pick(!fifo_empty, dbg_req, last_q);
          last_d  = grant;
          cnt_d   = '0;
          state_d = LAUNCH;
          if (grant == SRC_CPU) begin
            fifo_pop  = 1'b1;
            tx_data_d = fifo_rdata;
          end else begin
            dbg_ack_d = 1'b1;
            tx_data_d = dbg_data;
          end
        end
      end
      LAUNCH: begin
        // The strobe cycle counts towards the busy timeout.
        cnt_d   = cnt_q + CntW'(1);
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_IDLE;
        end else if (cnt_q == CntW'(BUSY_TIMEOUT - 1)) begin
          timeout_set = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      WAIT_IDLE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky error flags; a set in the same cycle as err_clr wins.
  always_comb begin
    ovf_set      = cpu_wr & fifo_full & ~fifo_pop;
    overflow_d   = overflow_q;
    tx_timeout_d = tx_timeout_q;
    if (err_clr) begin
      overflow_d   = 1'b0;
      tx_timeout_d = 1'b0;
    end
    if (ovf_set) begin
      overflow_d = 1'b1;
    end
    if (timeout_set) begin
      tx_timeout_d = 1'b1;
    end
  end

  // State registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_q       <= SRC_DBG;
      tx_data_q    <= '0;
      dbg_ack_q    <= 1'b0;
      cnt_q        <= '0;
      overflow_q   <= 1'b0;
      tx_timeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      tx_data_q    <= tx_data_d;
      dbg_ack_q    <= dbg_ack_d;
      cnt_q        <= cnt_d;
      overflow_q   <= overflow_d;
      tx_timeout_q <= tx_timeout_d;
    end
  end

  // Gate the strobe with reset so an in-flight LAUNCH cannot fire in the reset cycle.
  assign tx_en      = (state_q == LAUNCH) & ~reset;
  assign tx_data    = tx_data_q;
  assign dbg_ack    = dbg_ack_q;
  assign cpu_full   = fifo_full;
  assign overflow   = overflow_q;
  assign tx_timeout = tx_timeout_q;
  assign irq_empty  = fifo_empty & (state_q == IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, CPU transmit FIFO depth in bytes (power of 2, 2..256).
REQ-002 SHALL have parameter BUSY_TIMEOUT, default 64, clk cycles allowed for tx_busy to rise after tx_en.
REQ-003 SHALL have ports:
- clk  in  1  UART core clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- cpu_wr  in  1  CPU byte-write strobe, one byte per cycle high.
- cpu_data  in  8  CPU byte.
- cpu_full  out  1  FIFO full.
- cpu_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- dbg_req  in  1  debug-monitor request, held until acked.
- dbg_data  in  8  debug byte, stable while dbg_req high.
- dbg_ack  out  1  one-cycle pulse, debug byte taken.
- tx_data  out  8  byte to UART core.
- tx_en  out  1  one-cycle launch strobe to UART core.
- tx_busy  in  1  UART core transmitting.
- err_clr  in  1  clears sticky error flags.
- overflow  out  1  sticky, CPU write dropped.
- tx_timeout  out  1  sticky, tx_busy never rose.
- irq_empty  out  1  FIFO empty and FSM in IDLE.

Function
REQ-004 SHALL implement FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE.
REQ-005 IDLE: with a source pending, SHALL latch the granted byte into tx_data, pop the FIFO or pulse dbg_ack, and go to LAUNCH next cycle.
REQ-006 Arbitration SHALL be round-robin: if both are pending, grant the source not granted last; a single pending source is granted immediately; after reset, last-granted = debug (CPU wins first tie).
REQ-007 LAUNCH: SHALL drive tx_en=1 for exactly one cycle, then go to WAIT_BUSY.
REQ-008 WAIT_BUSY: tx_busy=1 -> WAIT_IDLE; after BUSY_TIMEOUT cycles without tx_busy SHALL set tx_timeout and return to IDLE; the byte is discarded, not retried.
REQ-009 WAIT_IDLE: tx_busy=0 -> IDLE; a new grant is possible in that IDLE cycle.
REQ-010 Minimum spacing between tx_en pulses SHALL be 4 cycles.
REQ-011 tx_data SHALL hold the latched byte from grant until the next grant.
REQ-012 A cpu_wr while full SHALL be dropped and set overflow, unless a pop occurs in the same cycle, in which case the write SHALL be accepted.
REQ-013 A simultaneous push and pop SHALL leave cpu_level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-014 cpu_full and cpu_level SHALL be registered and reflect the state after the current cycle's push/pop.
REQ-015 err_clr SHALL clear overflow and tx_timeout; a same-cycle set SHALL take priority over the clear.
REQ-016 irq_empty SHALL be combinational from the registered FIFO-empty flag and the FSM state.

Reset
REQ-017 Reset SHALL force: state IDLE, FIFO empty, cpu_level 0, cpu_full 0, tx_en 0, dbg_ack 0, tx_data 8'h00, overflow 0, tx_timeout 0, timeout counter 0, last-granted = debug.
REQ-018 Reset mid-transfer SHALL abandon the in-flight byte and discard FIFO contents, with no tx_en pulse in the reset cycle.

Structure
REQ-019 The FSM state enum and the source-select enum (SRC_CPU, SRC_DBG) SHALL live in shared package uart_pkg.
REQ-020 The FIFO SHALL be sub-module sync_fifo (parameterised width and depth, push/pop/full/empty/level).

Verification
REQ-021 Reset, then CPU writes 8'h41, 8'h42 back-to-back with tx_busy modelled 10 cycles after tx_en -> tx_en pulses carry 41, then 42; irq_empty rises after the second byte's tx_busy falls.
REQ-022 dbg_req with 8'hD0 while FIFO holds 8'h01, 8'h02 -> send order 01, D0, 02; dbg_ack pulses once.
REQ-023 17 CPU writes with tx_busy held high -> first byte is taken into tx_data; the next 16 fill the FIFO to cpu_level 16; 0 writes are dropped; an 18th write -> overflow=1; err_clr -> overflow=0.
REQ-024 tx_busy never asserted -> tx_timeout=1 exactly 64 cycles after tx_en; FSM in IDLE; the next FIFO byte launches.
REQ-025 FIFO full with a pop and cpu_wr in the same cycle -> write accepted; cpu_level stays 16; overflow stays 0.
REQ-026 Reset asserted in WAIT_IDLE with 3 bytes queued -> cpu_level 0, state IDLE, no tx_en until a new write.
